adder_pipe_nbit: RTL and testbench
==================================

// Module: adder_pipe_nbit
// PURPOSE
//  Parametrised, pipelined N-bit adder (successor to the 4-bit combinational adder).
//  - Splits operands into CHUNK_BITS slices; one slice is added per stage, and the carry ripples stage-to-stage.
//  - Valid/ready handshake on both sides gives one result per clock at full rate.
//  - Overflow flag is selectable: unsigned carry-out, or two's-complement signed overflow.
// PARAMETERS
//  NUM_BITS    16  operand/sum width; must be a multiple of CHUNK_BITS
//  CHUNK_BITS  4   bits added per pipeline stage; STAGES = NUM_BITS/CHUNK_BITS (>=1)
// PORTS
//  clk          in   1         system clock, rising edge
//  n_rst        in   1         synchronous active-low reset
//  in_valid     in   1         a/b/carry_in/signed_mode valid this cycle
//  in_ready     out  1         adder accepts input this cycle
//  a            in   NUM_BITS  operand A
//  b            in   NUM_BITS  operand B
//  carry_in     in   1         carry into bit 0
//  signed_mode  in   1         1: overflow = signed overflow; 0: overflow = carry-out
//  out_valid    out  1         sum/overflow valid
//  out_ready    in   1         consumer accepts result this cycle
//  sum          out  NUM_BITS  (a + b + carry_in) mod 2^NUM_BITS
//  overflow     out  1         see BEHAVIOUR
// BEHAVIOUR
//  - Reset: if n_rst==0 at a clk edge, all stage valid bits clear and all data registers clear.
//    While held in reset and after release: out_valid=0, sum=0, overflow=0, in_ready=1.
//  - Reset mid-operation: in-flight results are discarded, not flushed.
//  - Transfers: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
//  - Pipeline: STAGES register stages, each holding a valid bit.
//    - Stage k holds: sum chunks 0..k, the running carry, the unprocessed upper chunks of a/b, and the captured signed_mode.
//    - Stage 0 computes chunk 0 from a, b and carry_in in the accept cycle.
//  - Latency: a result accepted at edge t appears on sum/overflow with out_valid=1 after edge t+STAGES-1.
//    Example: STAGES=4 means valid 3 cycles after the accept edge; STAGES=1 gives a registered adder with 1-cycle latency.
//  - Stall: global stall, stall = out_valid && !out_ready.
//    - When stalled, every stage holds and in_ready=0.
//    - Otherwise all stages advance and in_ready=1.
//    - in_ready depends only on registered out_valid and out_ready (no comb path from in_valid).
//  - Bubbles: if in_valid=0 on an advancing cycle, stage 0's valid bit loads 0. Bubbles propagate, they are not compressed.
//  - Output stability: while out_valid && !out_ready, sum and overflow must not change.
//  - Overflow rules, with c_msb = carry out of bit NUM_BITS-1:
//    - signed_mode=0: overflow = c_msb.
//    - signed_mode=1: overflow = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), with carry_in included in sum.
//  - Mode is latched per transaction: signed_mode is captured at accept and travels with the data, so mode may change every cycle.
//  - Widths: all internal chunk sums are CHUNK_BITS+1 bits wide; no X or truncation beyond the defined mod-2^N wrap.
//  - Simultaneous accept and output on the same edge is legal and required for full throughput.
// STRUCTURE
//  - Shared package adder_pkg: localparam defaults (NUM_BITS, CHUNK_BITS) and a typedef for the stage payload struct {valid, carry, signed_mode, partial sum, remaining a/b}.
//  - Sub-module adder_chunk: combinational CHUNK_BITS adder (a, b, cin -> sum, cout, plus the MSB carry-in needed for the signed flag).
//    Instantiated once per stage via a generate loop.
//  - Top level: stage registers, valid/stall logic, output flag selection.
// TESTING (NUM_BITS=16, CHUNK_BITS=4, STAGES=4 unless noted)
//  1. Hold n_rst=0 for 2 clk, then release
//     -> out_valid=0, sum=0, overflow=0, in_ready=1.
//  2. a=16'hFFFF, b=16'h0000, cin=1, signed_mode=0, out_ready=1
//     -> 3 cycles after accept: sum=16'h0000, overflow=1 (carry ripples through all 4 stages).
//  3. a=16'h7FFF, b=16'h0001, cin=0, signed_mode=1
//     -> sum=16'h8000, overflow=1.
//     Same operands with signed_mode=0 -> overflow=0.
//  4. Stream 8 back-to-back inputs (a=i, b=2*i, mixed modes), out_ready=1
//     -> 8 consecutive out_valid cycles, in order, sum=3*i; in_ready stays 1 throughout.
//  5. With a full pipeline, drop out_ready=0 for 5 cycles
//     -> in_ready=0 and sum/overflow held constant; on out_ready=1 results resume in order, none lost or duplicated.
//  6. Assert n_rst=0 for 1 cycle with 3 results in flight
//     -> out_valid=0 next cycle, no stale result ever appears.
//     Repeat exhaustive 4-bit checks with NUM_BITS=8, CHUNK_BITS=4 (2^17 cases vs a+b+cin reference model).

Source files
------------

// File: rtl/adder_pkg.sv
// Shared defaults, per-stage control payload and overflow selection for the pipelined adder.
package adder_pkg;

  localparam int DEFAULT_NUM_BITS   = 16;
  localparam int DEFAULT_CHUNK_BITS = 4;

  // Width-independent part of a stage payload; data fields are sized by the top.
  typedef struct packed {
    logic valid;
    logic carry;
    logic smode;
    logic ovf;
  } stage_ctrl_t;

  // Signed overflow is carry-into-MSB xor carry-out-of-MSB.
  function automatic logic sel_overflow(input logic smode, input logic c_msb_in, input logic c_out);
    return smode ? (c_msb_in ^ c_out) : c_out;
  endfunction

endpackage

// File: rtl/adder_pipe_nbit_chunk.sv
// Combinational CHUNK_BITS slice adder; also exposes the carry into its own MSB.
module adder_chunk
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_CHUNK_BITS
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_c_msb_in
);

  logic [WIDTH:0] w_full;

  assign w_full     = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
  assign o_sum      = w_full[WIDTH-1:0];
  assign o_cout     = w_full[WIDTH];
  // Sum bit = a ^ b ^ cin, so the MSB carry-in falls out of the three MSBs.
  assign o_c_msb_in = i_a[WIDTH-1] ^ i_b[WIDTH-1] ^ w_full[WIDTH-1];

endmodule

// File: rtl/adder_pipe_nbit.sv
// Pipelined N-bit adder: one CHUNK_BITS slice per stage, carry rippling stage to stage,
// global stall when the output is valid but not taken.
module adder_pipe_nbit
  import adder_pkg::*;
#(
  parameter int NUM_BITS   = DEFAULT_NUM_BITS,
  parameter int CHUNK_BITS = DEFAULT_CHUNK_BITS
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                carry_in,
  input  logic                signed_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_BITS-1:0] sum,
  output logic                overflow
);

  localparam int STAGES = NUM_BITS / CHUNK_BITS;
  localparam int LAST   = STAGES - 1;

  typedef struct packed {
    stage_ctrl_t         ctrl;
    logic [NUM_BITS-1:0] psum;
    logic [NUM_BITS-1:0] a;
    logic [NUM_BITS-1:0] b;
  } stage_t;

  stage_t r_stage [STAGES];
  stage_t w_next  [STAGES];
  logic   w_stall;

  assign w_stall  = r_stage[LAST].ctrl.valid && !out_ready;
  assign in_ready = !w_stall;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      stage_t                w_src;
      stage_t                w_nxt;
      logic [CHUNK_BITS-1:0] w_chunk_sum;
      logic                  w_cout;
      logic                  w_c_msb_in;

      if (gi == 0) begin : g_first
        // Bubbles enter as an all-zero payload so idle stages never show stale data.
        always_comb begin
          w_src = '0;
          if (in_valid) begin
            w_src.ctrl.valid = 1'b1;
            w_src.ctrl.carry = carry_in;
            w_src.ctrl.smode = signed_mode;
            w_src.a          = a;
            w_src.b          = b;
          end
        end
      end else begin : g_rest
        assign w_src = r_stage[gi-1];
      end

      adder_chunk #(
        .WIDTH(CHUNK_BITS)
      ) u_chunk (
        .i_a       (w_src.a[gi*CHUNK_BITS +: CHUNK_BITS]),
        .i_b       (w_src.b[gi*CHUNK_BITS +: CHUNK_BITS]),
        .i_cin     (w_src.ctrl.carry),
        .o_sum     (w_chunk_sum),
        .o_cout    (w_cout),
        .o_c_msb_in(w_c_msb_in)
      );

      // Only the last stage's flag reaches the port; earlier ones are overwritten downstream.
      always_comb begin
        w_nxt                                      = w_src;
        w_nxt.psum[gi*CHUNK_BITS +: CHUNK_BITS]    = w_chunk_sum;
        w_nxt.ctrl.carry                           = w_cout;
        w_nxt.ctrl.ovf                             = sel_overflow(w_src.ctrl.smode, w_c_msb_in, w_cout);
      end

      assign w_next[gi] = w_nxt;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
    end else if (!w_stall) begin
      for (int i = 0; i < STAGES; i++) r_stage[i] <= w_next[i];
    end
  end

  assign out_valid = r_stage[LAST].ctrl.valid;
  assign sum       = r_stage[LAST].psum;
  assign overflow  = r_stage[LAST].ctrl.ovf;

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Directed-vector bench for the pipelined adder (16/4) plus a randomised 8/4 scoreboard run.
module tb_adder_pipe_nbit;

  localparam int NB = 16;
  localparam int CB = 4;
  localparam int ST = NB / CB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          n_rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NB-1:0] a = '0;
  logic [NB-1:0] b = '0;
  logic          carry_in = 1'b0;
  logic          signed_mode = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [NB-1:0] sum;
  logic          overflow;

  logic       in8_valid = 1'b0;
  logic       in8_ready;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       cin8 = 1'b0;
  logic       sm8 = 1'b0;
  logic       out8_valid;
  logic       out8_ready = 1'b1;
  logic [7:0] sum8;
  logic       ovf8;

  adder_pipe_nbit #(.NUM_BITS(NB), .CHUNK_BITS(CB)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carry_in(carry_in), .signed_mode(signed_mode),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .overflow(overflow)
  );

  adder_pipe_nbit #(.NUM_BITS(8), .CHUNK_BITS(4)) dut8 (
    .clk(clk), .n_rst(n_rst), .in_valid(in8_valid), .in_ready(in8_ready),
    .a(a8), .b(b8), .carry_in(cin8), .signed_mode(sm8),
    .out_valid(out8_valid), .out_ready(out8_ready), .sum(sum8), .overflow(ovf8)
  );

  typedef struct {
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    logic          cin;
    logic          sm;
    logic [NB-1:0] s;
    logic          ov;
  } vec_t;

  typedef struct packed { logic [NB-1:0] s; logic ov; } exp_t;
  typedef struct packed { logic [7:0] s; logic ov; } exp8_t;

  vec_t  tbl [14];
  exp_t  q [$];
  exp8_t q8 [$];
  exp_t  cur_exp = '0;
  int    n_vec = 0;
  int    n_err = 0;
  int    n_pop = 0;
  int    run_len = 0;
  int    max_run = 0;
  logic [8:0] t9;
  exp8_t      e8;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // 16-bit scoreboard: compares the head entry whenever out_valid, including stall cycles.
  always @(negedge clk) begin
    if (n_rst !== 1'b1) begin
      q.delete();
      run_len = 0;
    end else begin
      if (out_valid) run_len++; else run_len = 0;
      if (run_len > max_run) max_run = run_len;
      if (out_valid) begin
        if (q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL stale_result: got sum=%h ovf=%b, required no valid output", sum, overflow);
        end else begin
          check(out_ready ? "result" : "hold", {15'd0, overflow, sum}, {15'd0, q[0].ov, q[0].s});
          if (out_ready) begin
            void'(q.pop_front());
            n_pop++;
          end
        end
      end
      if (in_valid && in_ready) q.push_back(cur_exp);
    end
  end

  // 8-bit scoreboard against a plain a+b+cin reference.
  always @(negedge clk) begin
    if (n_rst !== 1'b1) begin
      q8.delete();
    end else begin
      if (out8_valid) begin
        if (q8.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL stale_result8: got sum=%h ovf=%b, required no valid output", sum8, ovf8);
        end else begin
          check("result8", {23'd0, ovf8, sum8}, {23'd0, q8[0].ov, q8[0].s});
          if (out8_ready) void'(q8.pop_front());
        end
      end
      if (in8_valid && in8_ready) begin
        t9   = {1'b0, a8} + {1'b0, b8} + {8'd0, cin8};
        e8.s = t9[7:0];
        e8.ov = sm8 ? ((a8[7] == b8[7]) && (t9[7] != a8[7])) : t9[8];
        q8.push_back(e8);
      end
    end
  end

  task automatic send(input vec_t v, output int waits);
    bit acc;
    acc         = 1'b0;
    waits       = 0;
    a           = v.a;
    b           = v.b;
    carry_in    = v.cin;
    signed_mode = v.sm;
    cur_exp     = '{s: v.s, ov: v.ov};
    in_valid    = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1; else waits++;
    end
    if (!acc) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, required acceptance");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 40 && q.size() != 0; k++) begin
      @(posedge clk); #2;
    end
    check(name, q.size(), 0);
  endtask

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 7))
      0:       return 8'h00;
      1:       return 8'h7F;
      2:       return 8'h80;
      3:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int   w;
    int   lat;
    int   pop0;
    vec_t v;

    tbl[0]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1};
    tbl[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1};
    tbl[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0};
    tbl[3]  = '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1};
    tbl[4]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1};
    tbl[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 1'b0};
    tbl[6]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1};
    tbl[7]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0};
    tbl[8]  = '{16'h0FFF, 16'h0001, 1'b0, 1'b1, 16'h1000, 1'b0};
    tbl[9]  = '{16'h7FFF, 16'h0000, 1'b1, 1'b1, 16'h8000, 1'b1};
    tbl[10] = '{16'h8000, 16'hFFFF, 1'b0, 1'b1, 16'h7FFF, 1'b1};
    tbl[11] = '{16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0};
    tbl[12] = '{16'hF000, 16'h1000, 1'b0, 1'b0, 16'h0000, 1'b1};
    tbl[13] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0};

    // Reset held for two edges, then released.
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(negedge clk);
    check("rel_out_valid", out_valid, 0);
    check("rel_sum", sum, 0);
    check("rel_overflow", overflow, 0);
    check("rel_in_ready", in_ready, 1);

    // Latency: full carry ripple, result after STAGES-1 further edges.
    @(posedge clk); #1;
    send(tbl[0], w);
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) break;
      lat++;
    end
    check("latency", lat, ST - 1);
    drain("drain_latency");

    // Directed table, streamed back to back.
    for (int i = 0; i < 14; i++) send(tbl[i], w);
    drain("drain_table");

    // Eight back-to-back inputs, mixed modes, expect an unbroken output run.
    max_run = 0;
    for (int i = 1; i <= 8; i++) begin
      v.a = 16'(i); v.b = 16'(2 * i); v.cin = 1'b0; v.sm = i[0];
      v.s = 16'(3 * i); v.ov = 1'b0;
      send(v, w);
      check("stream_in_ready", w, 0);
    end
    drain("drain_stream");
    check("stream_run", max_run, 8);

    // Fill the pipe with out_ready low, hold five cycles, then release.
    out_ready = 1'b0;
    for (int i = 7; i <= 10; i++) send(tbl[i], w);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
    end
    @(posedge clk); #1;
    pop0 = n_pop;
    out_ready = 1'b1;
    drain("drain_stall");
    check("stall_count", n_pop - pop0, 4);

    // Reset with three results in flight: none may surface afterwards.
    for (int i = 11; i <= 13; i++) send(tbl[i], w);
    n_rst = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(negedge clk);
    check("midrst_sum", sum, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_in_ready", in_ready, 1);
    for (int k = 0; k < 8; k++) begin
      check("midrst_out_valid", out_valid, 0);
      @(negedge clk);
    end

    // Randomised 8-bit run with random bubbles and back-pressure.
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      in8_valid  = ($urandom_range(0, 3) != 0);
      a8         = pick8();
      b8         = pick8();
      cin8       = 1'($urandom);
      sm8        = 1'($urandom);
      out8_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in8_valid  = 1'b0;
    out8_ready = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    check("drain8", q8.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
